// File: rtl/ps2_key_receiver_if.sv
// Read-side FIFO and key-event signals between the PS/2 receiver (master)
// and its consumer (slave).
interface ps2_key_receiver_if;
  logic       rdn;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;
  logic       newKey;
  logic [7:0] key_code;
  logic       key_ext;

  modport master (
    input  rdn,
    output data, ready, overflow, frame_err, newKey, key_code, key_ext
  );
  modport slave (
    output rdn,
    input  data, ready, overflow, frame_err, newKey, key_code, key_ext
  );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame capture with watchdog, 8-deep scan-code FIFO,
// and an in-line make/break/extended decoder producing a newKey pulse.
module ps2_key_receiver #(
  parameter int TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_key_receiver_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  logic            ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic            ps2_data_p0, ps2_data_p1;
  logic            fall_p2;
  logic [3:0]      bitcnt;
  logic [9:0]      shreg;
  logic [WD_W-1:0] wd_cnt;
  logic            frame_done, frame_ok, byte_vld;
  logic [7:0]      byte_val;
  logic [7:0]      mem [8];
  logic [2:0]      wr_ptr, rd_ptr;
  logic [3:0]      count;
  logic            fifo_full, fifo_rd, fifo_wr;
  logic            overflow_r, frame_err_r;
  dec_state_t      state;
  logic [7:0]      held_code;
  logic            held_ext, held_v;
  logic            mk_vld, rel_vld, cur_ext;
  logic            new_key_r;
  logic [7:0]      key_code_r;
  logic            key_ext_r;

  // ---- stage p0..p2: synchronisers; p2 is the ps2_clk history flop
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      {ps2_clk_p0, ps2_clk_p1, ps2_clk_p2} <= 3'b111;
      {ps2_data_p0, ps2_data_p1}           <= 2'b11;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign fall_p2    = ps2_clk_p2 & ~ps2_clk_p1;
  assign frame_done = fall_p2 && (bitcnt == 4'd10);
  // shreg = {parity, data[7:0], start}; the stop bit is still on the pin
  assign frame_ok   = ~shreg[0] & ps2_data_p1 & (^shreg[9:1]);
  assign byte_vld   = frame_done & frame_ok;
  assign byte_val   = shreg[8:1];

  // ---- frame capture: LSB-first shift, bit counter, inactivity watchdog
  always_ff @(posedge clk) begin
    if (fall_p2) shreg <= {ps2_data_p1, shreg[9:1]};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bitcnt      <= 4'd0;
      wd_cnt      <= '0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= frame_done & ~frame_ok;
      if (fall_p2) begin
        wd_cnt <= '0;
        bitcnt <= (bitcnt == 4'd10) ? 4'd0 : bitcnt + 4'd1;
      end else if (bitcnt != 4'd0) begin
        if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          bitcnt <= 4'd0;
          wd_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // ---- FIFO: a pop in the same cycle frees the slot a full-FIFO write needs
  assign fifo_full = count[3];
  assign fifo_rd   = ~bus.rdn & (count != 4'd0);
  assign fifo_wr   = byte_vld & (~fifo_full | fifo_rd);

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= byte_val;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr     <= 3'd0;
      rd_ptr     <= 3'd0;
      count      <= 4'd0;
      overflow_r <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 3'd1;
      if (fifo_rd) rd_ptr <= rd_ptr + 3'd1;
      count <= count + 4'(fifo_wr) - 4'(fifo_rd);
      if (byte_vld & fifo_full & ~fifo_rd) overflow_r <= 1'b1;
      else if (fifo_rd)                    overflow_r <= 1'b0;
    end
  end

  // ---- decoder: classify the incoming byte by current prefix state
  always_comb begin
    mk_vld  = 1'b0;
    rel_vld = 1'b0;
    cur_ext = 1'b0;
    case (state)
      IDLE:    mk_vld  = byte_vld && !(byte_val inside {8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE});
      EXT: begin
        mk_vld  = byte_vld && (byte_val != 8'hF0);
        cur_ext = 1'b1;
      end
      BRK:     rel_vld = byte_vld;
      EXT_BRK: begin
        rel_vld = byte_vld;
        cur_ext = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
      held_v     <= 1'b0;
      new_key_r  <= 1'b0;
      key_code_r <= 8'h00;
      key_ext_r  <= 1'b0;
    end else begin
      new_key_r <= 1'b0;
      if (byte_vld) begin
        case (state)
          IDLE:    state <= (byte_val == 8'hE0) ? EXT :
                            (byte_val == 8'hF0) ? BRK : IDLE;
          EXT:     state <= (byte_val == 8'hF0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end
      // typematic repeats of the held key are swallowed
      if (mk_vld && !(held_v && held_code == byte_val && held_ext == cur_ext)) begin
        new_key_r  <= 1'b1;
        key_code_r <= byte_val;
        key_ext_r  <= cur_ext;
        held_code  <= byte_val;
        held_ext   <= cur_ext;
        held_v     <= 1'b1;
      end
      if (rel_vld && held_v && held_code == byte_val && held_ext == cur_ext)
        held_v <= 1'b0;
    end
  end

  assign bus.data      = (count != 4'd0) ? mem[rd_ptr] : 8'h00;
  assign bus.ready     = (count != 4'd0);
  assign bus.overflow  = overflow_r;
  assign bus.frame_err = frame_err_r;
  assign bus.newKey    = new_key_r;
  assign bus.key_code  = key_code_r;
  assign bus.key_ext   = key_ext_r;
endmodule
